// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and
// default geometry constants.
package regfile_mp_pkg;

  // Default register width in bits and address width.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Soft-clear sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage : regfile_mp_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port: entry select, write-to-read forwarding with
// byte-enable merge, and hardwired-zero gating for address 0.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]   ra_i,
  input  logic [DATA_W-1:0]   mem_i [2**ADDR_W],
  input  logic                byp_en_i,
  input  logic [ADDR_W-1:0]   wa_i,
  input  logic [DATA_W-1:0]   wd_i,
  input  logic [DATA_W/8-1:0] wbe_i,
  output logic [DATA_W-1:0]   rd_o
);

  localparam int NB = DATA_W / 8;

  logic hit;

  // Select the stored entry, overlay enabled bytes of an in-flight write to
  // the same address, then force zero for the hardwired entry.
  always_comb begin
    hit  = (BYPASS != 0) && byp_en_i && (ra_i == wa_i);
    rd_o = mem_i[ra_i];
    if (hit) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) begin
          rd_o[b*8 +: 8] = wd_i[b*8 +: 8];
        end
      end
    end
    if ((ZERO_REG != 0) && (ra_i == '0)) begin
      rd_o = '0;
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes, optional hardwired
// zero entry, optional write forwarding, and a one-entry-per-cycle soft
// clear sweep. Writes arriving while the sweep runs are dropped and flagged.
//
// Handshake: there is no back-pressure. A write is accepted whenever
// we_i=1 and busy_o=0 and commits at that rising edge; a write offered while
// busy_o=1 is discarded and wdrop_o pulses for exactly the following cycle.
// init_i is sampled only in IDLE; it is ignored while busy_o=1.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        wa_i,
  input  logic [DATA_W-1:0]        wd_i,
  input  logic [DATA_W/8-1:0]      wbe_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o,
  input  logic                     init_i,
  output logic                     busy_o,
  output logic                     wdrop_o,
  output state_e                   state_o,
  output logic [ADDR_W-1:0]        sweep_ptr_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;
  // The hardwired entry never needs clearing, so the sweep skips it.
  localparam logic [ADDR_W-1:0] PTR_START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wdrop_q, wdrop_d;
  logic              sweep_clr;
  logic              busy;
  logic              wr_commit;

  assign busy = (state_q == SWEEP);

  // A write commits only outside the sweep and never to the hardwired entry.
  assign wr_commit = we_i && !busy && !((ZERO_REG != 0) && (wa_i == '0));

  // Sequencer next state: start on init in IDLE, walk the pointer in SWEEP
  // and return to IDLE after the last entry without wrapping.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_clr = 1'b0;
    wdrop_d   = we_i && busy;
    case (state_q)
      IDLE: begin
        if (init_i) begin
          state_d = SWEEP;
          ptr_d   = PTR_START;
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = PTR_START;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = PTR_START;
      end
    endcase
  end

  // Sequencer and drop-flag registers.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      ptr_q   <= PTR_START;
      wdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdrop_q <= wdrop_d;
    end
  end

  // Storage: sweep clears one whole entry per cycle, otherwise a committed
  // write updates only its enabled bytes.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (sweep_clr) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) begin
          mem_q[wa_i][b*8 +: 8] <= wd_i[b*8 +: 8];
        end
      end
    end
  end

  // Read ports share the storage and see the same forwarding source.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .ra_i    (ra_i[p*ADDR_W +: ADDR_W]),
      .mem_i   (mem_q),
      .byp_en_i(wr_commit),
      .wa_i    (wa_i),
      .wd_i    (wd_i),
      .wbe_i   (wbe_i),
      .rd_o    (rd_o[p*DATA_W +: DATA_W])
    );
  end

  assign busy_o      = busy;
  assign wdrop_o     = wdrop_q;
  assign state_o     = state_q;
  assign sweep_ptr_o = ptr_q;

endmodule : regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL hardwire entry 0 to zero when 1.
REQ-005 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-006 Clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-007 Clr  in  1  reset, asynchronous, active-high.
REQ-008 We  in  1  write request.
REQ-009 Wa  in  ADDR_W  write address.
REQ-010 Wd  in  DATA_W  write data.
REQ-011 Wbe  in  DATA_W/8  byte enables; bit i covers Wd[8i+7:8i].
REQ-012 Ra  in  NUM_RD*ADDR_W  read addresses; port p uses slice p.
REQ-013 Rd  out  NUM_RD*DATA_W  read data; port p drives slice p.
REQ-014 Init  in  1  single-cycle request to start a soft clear sweep.
REQ-015 Busy  out  1  high while the sweep runs.
REQ-016 Wdrop  out  1  registered pulse: a write was discarded the previous cycle.

Function
REQ-017 Reads SHALL be combinational: Rd[p] = entry[Ra[p]] in the same cycle.
REQ-018 Write SHALL commit at the rising edge when We=1, Busy=0; only bytes with Wbe[i]=1 change.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be ignored without Wdrop, and reads of address 0 SHALL return 0.
REQ-020 With BYPASS=1, when We=1, Busy=0 and Ra[p]=Wa (nonzero if ZERO_REG=1), Rd[p] SHALL return Wd in enabled bytes and stored bytes elsewhere; with BYPASS=0, Rd[p] SHALL return the old value.
REQ-021 Two or more read ports on the same address SHALL return identical data.
REQ-022 FSM states IDLE and SWEEP; IDLE->SWEEP on Init=1; SWEEP->IDLE after the last entry is cleared.
REQ-023 Sweep pointer SHALL start at 1 (ZERO_REG=1) or 0 (ZERO_REG=0), clear one full entry per cycle, and stop at depth-1; sweep length SHALL be depth-1 or depth cycles.
REQ-024 Busy SHALL be 1 exactly in SWEEP; it SHALL rise the cycle after Init and fall the cycle after the last entry is cleared.
REQ-025 Init while Busy=1 SHALL be ignored (no restart).
REQ-026 We=1 while Busy=1 SHALL be discarded and SHALL set Wdrop=1 for the following cycle.
REQ-027 Init and We in the same IDLE cycle: the write SHALL commit, then the sweep SHALL clear it.
REQ-028 Reads during SWEEP SHALL return current contents (cleared or not); no bypass SHALL apply.
REQ-029 Sweep pointer SHALL not wrap; after depth-1 the FSM SHALL return to IDLE.

Reset
REQ-030 Clr=1 SHALL immediately clear all entries to 0, FSM to IDLE, pointer to start value, Busy=0, Wdrop=0.
REQ-031 Clr asserted mid-sweep SHALL abort the sweep; no residual Busy after release.
REQ-032 First write after Clr release SHALL commit on the first rising edge with Clr=0.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (IDLE=0, SWEEP=1) and the default DATA_W/ADDR_W constants.
REQ-034 One sub-module, regfile_rdport, SHALL implement one read port (mux, zero gating, bypass merge), instantiated NUM_RD times by generate.
REQ-035 Storage SHALL be a flat array of depth entries; no per-entry instance.

Verification
REQ-036 Clr pulse, then write 0xDEADBEEF to r5, Wbe=4'hF; next cycle Ra0=5 -> Rd0=0xDEADBEEF.
REQ-037 r5=0xDEADBEEF, write Wd=0x11223344, Wbe=4'b0101 to r5 with Ra0=5 same cycle -> Rd0=0xDE22BE44 (BYPASS=1), 0xDEADBEEF (BYPASS=0); after edge 0xDE22BE44 for both.
REQ-038 Write 0xFFFFFFFF to r0, Ra0=Ra1=0 -> Rd0=Rd1=0, Wdrop=0.
REQ-039 Fill r1..r31 with index, pulse Init -> Busy high 31 cycles; write to r7 during sweep -> Wdrop=1 next cycle; after Busy falls all reads return 0.
REQ-040 Start sweep, assert Clr on sweep cycle 10 -> Busy=0 immediately, all entries 0; Init after release restarts full 31-cycle sweep.
REQ-041 Init pulsed again mid-sweep -> total Busy duration unchanged (31 cycles).
